// File: rtl/delay_timer_scheduler_if.sv
// Handshake bundle between the game-logic requesters and the shared delay
// timer scheduler.
//
// Handshake: a requester raises req[i] (level) with its delay on
// req_delay[i*CNT_W +: CNT_W] and keeps req high until it sees done[i]. The
// delay is sampled only in the cycle the grant is taken. Dropping req[i]
// while granted cancels the timing run without a done pulse. After done[i]
// the requester must drop req[i], or it re-enters arbitration.
interface delay_timer_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 20
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] req_delay;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [CNT_W-1:0]         count;
  logic [1:0]               state_dbg;

  // Requester side: drives requests, observes scheduler results.
  modport master (
    output req,
    output req_delay,
    input  grant,
    input  done,
    input  busy,
    input  count,
    input  state_dbg
  );

  // Scheduler side.
  modport slave (
    input  req,
    input  req_delay,
    output grant,
    output done,
    output busy,
    output count,
    output state_dbg
  );
endinterface

// File: rtl/delay_timer_scheduler.sv
// delay_timer_scheduler: one shared count-up timer arbitrated between
// NUM_REQ requesters. The winner's delay is latched at grant; the counter
// runs 0..delay, then a one-cycle done pulse goes back to the owner.
//
// Build option: define SCHED_FIXED_PRIO_EN to use fixed priority (lowest
// index wins) instead of round-robin. Timing is identical in both builds.
module delay_timer_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 20
) (
  input  logic                    Clk,
  input  logic                    Reset,
  delay_timer_scheduler_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Registered state
  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   limit_q;
  logic [IDX_W-1:0]   owner_q;

  // Next-state values
  state_t             state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [NUM_REQ-1:0] done_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic [CNT_W-1:0]   limit_nxt;
  logic [IDX_W-1:0]   owner_nxt;

  // Arbitration result
  logic               win_found;
  logic [IDX_W-1:0]   win;

  // Per-requester view of the packed delay bus
  logic [CNT_W-1:0]   delay_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_delay
    assign delay_arr[gi] = bus.req_delay[gi*CNT_W +: CNT_W];
  end

`ifdef SCHED_FIXED_PRIO_EN

  // Fixed priority: the lowest set request index wins.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && bus.req[IDX_W'(k)]) begin
        win_found = 1'b1;
        win       = IDX_W'(k);
      end
    end
  end

`else

  // Round-robin pointer: index of the requester served most recently.
  // Reset value NUM_REQ-1 gives requester 0 first priority.
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_nxt;
  int               scan_idx;

  // Round-robin: scan last+1, last+2, ... modulo NUM_REQ for the first request.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    scan_idx  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (int'(last_q) + k) % NUM_REQ;
      if (!win_found && bus.req[IDX_W'(scan_idx)]) begin
        win_found = 1'b1;
        win       = IDX_W'(scan_idx);
      end
    end
  end

  // Pointer moves to the owner whenever a run ends (done or cancel).
  always_comb begin
    last_nxt = last_q;
    if ((state_q == DONE) || ((state_q == RUN) && !bus.req[owner_q])) begin
      last_nxt = owner_q;
    end
  end

  // Pointer register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      last_q <= last_nxt;
    end
  end

`endif

  // Next-state and next-output logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_nxt = state_q;
    grant_nxt = grant_q;
    done_nxt  = '0;
    count_nxt = count_q;
    limit_nxt = limit_q;
    owner_nxt = owner_q;

    unique case (state_q)
      IDLE: begin
        count_nxt = '0;
        grant_nxt = '0;
        if (win_found) begin
          grant_nxt      = '0;
          grant_nxt[win] = 1'b1;
          limit_nxt      = delay_arr[win];
          owner_nxt      = win;
          state_nxt      = RUN;
        end
      end

      RUN: begin
        if (!bus.req[owner_q]) begin
          // Cancel takes precedence over expiry in the same cycle.
          state_nxt = IDLE;
          grant_nxt = '0;
          count_nxt = '0;
        end else if (count_q == limit_q) begin
          state_nxt          = DONE;
          done_nxt           = '0;
          done_nxt[owner_q]  = 1'b1;
        end else begin
          count_nxt = count_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        count_nxt = '0;
      end

      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        count_nxt = '0;
      end
    endcase
  end

  // Controller, counter and latched-limit registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      count_q <= '0;
      limit_q <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_nxt;
      grant_q <= grant_nxt;
      done_q  <= done_nxt;
      count_q <= count_nxt;
      limit_q <= limit_nxt;
      owner_q <= owner_nxt;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.count     = count_q;
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_delay_timer_scheduler.sv
// Directed bench for delay_timer_scheduler (NUM_REQ=4, CNT_W=20).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_delay_timer_scheduler;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 20;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  delay_timer_scheduler_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

  delay_timer_scheduler #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then step off the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_delay(input int idx, input int value);
    bus.req_delay[idx*CNT_W +: CNT_W] = CNT_W'(value);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(bus.grant), 32'd0);
    check({tag, "_done"},  32'(bus.done),  32'd0);
    check({tag, "_busy"},  32'(bus.busy),  32'd0);
    check({tag, "_count"}, 32'(bus.count), 32'd0);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.req       = '0;
    bus.req_delay = '0;

    // Reset state
    tick(2);
    rst = 1'b0;
    check_idle("reset");
    check("reset_state", 32'(bus.state_dbg), 32'd0);

    // Single long delay: requester 0, D=1500
    bus.req = 4'b0001;
    set_delay(0, 1500);
    tick(1);
    check("long_grant", 32'(bus.grant), 32'b0001);
    check("long_count0", 32'(bus.count), 32'd0);
    check("long_busy", 32'(bus.busy), 32'd1);
    tick(700);
    check("long_count700", 32'(bus.count), 32'd700);
    tick(800);
    check("long_count1500", 32'(bus.count), 32'd1500);
    check("long_nodone_early", 32'(bus.done), 32'd0);
    tick(1);
    check("long_done", 32'(bus.done), 32'b0001);
    check("long_done_grant", 32'(bus.grant), 32'b0001);
    check("long_done_count", 32'(bus.count), 32'd1500);
    bus.req = 4'b0000;
    tick(1);
    check_idle("long_end");

    // All four requesting, D=3 each; fresh reset so requester 0 leads
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_delay(i, 3);
    bus.req = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) begin
      tick(1);
      check("rr_grant", 32'(bus.grant), 32'(1 << i));
      check("rr_count0", 32'(bus.count), 32'd0);
      tick(3);
      check("rr_count3", 32'(bus.count), 32'd3);
      check("rr_nodone", 32'(bus.done), 32'd0);
      tick(1);
      check("rr_done", 32'(bus.done), 32'(1 << i));
      check("rr_done_grant", 32'(bus.grant), 32'(1 << i));
      bus.req[i] = 1'b0;
      tick(1);
      check("rr_gap_grant", 32'(bus.grant), 32'd0);
      check("rr_gap_busy", 32'(bus.busy), 32'd0);
    end

    // Zero delay: requester 1, D=0
    bus.req = 4'b0010;
    set_delay(1, 0);
    tick(1);
    check("d0_grant", 32'(bus.grant), 32'b0010);
    check("d0_nodone", 32'(bus.done), 32'd0);
    tick(1);
    check("d0_done", 32'(bus.done), 32'b0010);
    bus.req = 4'b0000;
    tick(1);
    check_idle("d0_end");

    // Cancel mid-run: requester 0, D=100, dropped at count 40
    bus.req = 4'b0001;
    set_delay(0, 100);
    tick(1);
    check("cancel_grant", 32'(bus.grant), 32'b0001);
    tick(40);
    check("cancel_count40", 32'(bus.count), 32'd40);
    bus.req = 4'b0000;
    tick(1);
    check_idle("cancel_end");
    check("cancel_state", 32'(bus.state_dbg), 32'd0);

    // Pointer advanced by the cancel: with 0 and 1 both asking, 1 goes first
    set_delay(1, 10);
    bus.req = 4'b0011;
    tick(1);
`ifdef SCHED_FIXED_PRIO_EN
    check("after_cancel_grant", 32'(bus.grant), 32'b0001);
`else
    check("after_cancel_grant", 32'(bus.grant), 32'b0010);
`endif
    bus.req = 4'b0000;
    tick(1);
    check_idle("after_cancel_end");

    // Cancel and expiry in the same cycle: cancel wins
    bus.req = 4'b0100;
    set_delay(2, 2);
    tick(1);
    check("tie_grant", 32'(bus.grant), 32'b0100);
    tick(2);
    check("tie_count2", 32'(bus.count), 32'd2);
    bus.req = 4'b0000;
    tick(1);
    check_idle("tie_end");
    tick(1);
    check("tie_no_late_done", 32'(bus.done), 32'd0);

    // Reset in the middle of a run
    bus.req = 4'b0100;
    set_delay(2, 200);
    tick(1);
    check("midrst_grant", 32'(bus.grant), 32'b0100);
    tick(57);
    check("midrst_count57", 32'(bus.count), 32'd57);
    rst     = 1'b1;
    bus.req = 4'b0000;
    tick(1);
    rst = 1'b0;
    check_idle("midrst");

    // Fresh request after reset; delay change after grant is ignored
    bus.req = 4'b1000;
    set_delay(3, 5);
    tick(1);
    check("post_rst_grant", 32'(bus.grant), 32'b1000);
    set_delay(3, 2);
    tick(5);
    check("latched_count5", 32'(bus.count), 32'd5);
    check("latched_nodone", 32'(bus.done), 32'd0);
    tick(1);
    check("latched_done", 32'(bus.done), 32'b1000);
    bus.req = 4'b0000;
    tick(1);
    check_idle("latched_end");

`ifdef SCHED_FIXED_PRIO_EN
    // Fixed priority: requester 0 held high wins every round
    for (int i = 0; i < NUM_REQ; i++) set_delay(i, 1);
    bus.req = 4'b1111;
    for (int r = 0; r < 3; r++) begin
      tick(1);
      check("fp_grant", 32'(bus.grant), 32'b0001);
      tick(2);
      check("fp_done", 32'(bus.done), 32'b0001);
      tick(1);
      check("fp_gap", 32'(bus.grant), 32'd0);
    end
    bus.req = 4'b0000;
    tick(3);
    check_idle("fp_end");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
